// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming 3x3 signed correlation over a raster-order image.
// Two line buffers feed a 3x3 window; products and sum+bias form a 2-stage pipeline.
module conv3x3_stream #(
  parameter int In_d_W  = 8,
  parameter int Wt_W    = 8,
  parameter int Out_d_W = 32,
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28
) (
  input  logic                      iClk,
  input  logic                      iRsn,
  input  logic                      iInValid,
  input  logic signed [In_d_W-1:0]  iPixel,
  input  logic [9*Wt_W-1:0]         iWeight,
  input  logic signed [Out_d_W-1:0] iBias,
  output logic                      oOutValid,
  output logic signed [Out_d_W-1:0] oOutData
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = In_d_W + Wt_W;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]              col;
  logic [RW-1:0]              row;
  logic signed [In_d_W-1:0]   lineA [IMG_W];
  logic signed [In_d_W-1:0]   lineB [IMG_W];
  logic signed [In_d_W-1:0]   win   [9];
  logic signed [PW-1:0]       prod  [9];
  logic                       v0, v1;
  logic signed [Out_d_W-1:0]  sum;

  always_ff @(posedge iClk or negedge iRsn)
    if (!iRsn) begin
      col       <= '0;
      row       <= '0;
      v0        <= 1'b0;
      v1        <= 1'b0;
      oOutValid <= 1'b0;
      oOutData  <= '0;
    end else begin
      // edge masking keeps stale line-buffer data from the previous frame out of results
      v0        <= iInValid && row >= RW'(2) && col >= CW'(2);
      v1        <= v0;
      oOutValid <= v1;
      if (v1) oOutData <= sum;
      if (iInValid) begin
        col <= col == COL_LAST ? '0 : col + 1'b1;
        if (col == COL_LAST) row <= row == ROW_LAST ? '0 : row + 1'b1;
      end
    end

  // lineA holds row-1, lineB holds row-2; window index 3*i+j, j=2 newest column
  always_ff @(posedge iClk) begin
    if (iInValid) begin
      lineA[col] <= iPixel;
      lineB[col] <= lineA[col];
      for (int r = 0; r < 3; r++) begin
        win[3*r]   <= win[3*r+1];
        win[3*r+1] <= win[3*r+2];
      end
      win[2] <= lineB[col];
      win[5] <= lineA[col];
      win[8] <= iPixel;
    end
    for (int i = 0; i < 9; i++) prod[i] <= win[i] * $signed(iWeight[i*Wt_W +: Wt_W]);
  end

  always_comb begin
    sum = iBias;
    for (int i = 0; i < 9; i++) sum = sum + Out_d_W'(prod[i]);
  end
endmodule

// File: tb/tb_conv3x3_stream.sv
// tb_conv3x3_stream: randomized and directed frames checked against a direct
// correlation model of each frame, including output timing relative to each beat.
module tb_conv3x3_stream;
  localparam int W = 28, H = 28, NOUT = (W-2)*(H-2);

  logic               iClk = 1'b0, iRsn = 1'b0, iInValid = 1'b0;
  logic signed [7:0]  iPixel = '0;
  logic [71:0]        iWeight = '0;
  logic signed [31:0] iBias = '0;
  logic               oOutValid;
  logic signed [31:0] oOutData;

  conv3x3_stream dut (
    .iClk(iClk), .iRsn(iRsn), .iInValid(iInValid), .iPixel(iPixel),
    .iWeight(iWeight), .iBias(iBias), .oOutValid(oOutValid), .oOutData(oOutData)
  );

  always #5 iClk = ~iClk;

  int tests = 0, fails = 0, cyc = 0, holdErr = 0;
  logic signed [7:0]  img [2][H][W];
  logic signed [7:0]  k [9];
  int                 accCyc [2][H][W];
  int                 obsVal [$];
  int                 obsCyc [$];
  logic signed [31:0] lastData = '0;

  always @(posedge iClk) cyc <= cyc + 1;

  always @(negedge iClk) begin
    if (!iRsn) lastData = '0;
    else if (oOutValid) begin
      obsVal.push_back(oOutData);
      obsCyc.push_back(cyc);
      lastData = oOutData;
    end else if (oOutData !== lastData) holdErr++;
  end

  function automatic int model(int f, int r, int c);
    int s = iBias;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += int'(k[3*i+j]) * int'(img[f][r-2+i][c-2+j]);
    return s;
  endfunction

  task automatic set_k();
    for (int i = 0; i < 9; i++) iWeight[i*8 +: 8] = k[i];
  endtask

  task automatic step(input logic v, input logic signed [7:0] p);
    iInValid = v;
    iPixel = p;
    @(posedge iClk);
    #1;
    iInValid = 1'b0;
  endtask

  task automatic send_frames(input int n, input int gap);
    for (int f = 0; f < n; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          if (gap == 1) step(1'b0, 8'($urandom));
          else if (gap == 2) repeat ($urandom_range(0, 2)) step(1'b0, 8'($urandom));
          step(1'b1, img[f][r][c]);
          accCyc[f][r][c] = cyc;
        end
    repeat (4) step(1'b0, 8'd0);
  endtask

  task automatic test_frame(input string name, input int n, input int gap);
    int idx = 0;
    int expv;
    obsVal.delete();
    obsCyc.delete();
    send_frames(n, gap);
    tests++;
    if (obsVal.size() !== n*NOUT) begin
      fails++;
      $display("FAIL %s count: got %0d outputs, expected %0d", name, obsVal.size(), n*NOUT);
    end
    for (int f = 0; f < n; f++)
      for (int r = 2; r < H; r++)
        for (int c = 2; c < W; c++) begin
          if (idx < obsVal.size()) begin
            expv = model(f, r, c);
            tests++;
            if (obsVal[idx] !== expv) begin
              fails++;
              if (fails <= 30) $display("FAIL %s value f%0d r%0d c%0d: got %0d, expected %0d", name, f, r, c, obsVal[idx], expv);
            end
            tests++;
            if (obsCyc[idx] !== accCyc[f][r][c] + 2) begin
              fails++;
              if (fails <= 30) $display("FAIL %s timing f%0d r%0d c%0d: got cycle %0d, expected %0d", name, f, r, c, obsCyc[idx], accCyc[f][r][c] + 2);
            end
          end
          idx++;
        end
  endtask

  task automatic fill(input int mode);
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          img[f][r][c] = mode == 0 ? 8'sd1 : mode == 1 ? 8'(c) : mode == 2 ? -8'sd128 : 8'($urandom);
  endtask

  task automatic test_reset();
    iRsn = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    tests++;
    if (oOutValid !== 1'b0 || oOutData !== 32'sd0) begin
      fails++;
      $display("FAIL reset_state: valid=%b data=%0d, expected 0/0", oOutValid, oOutData);
    end
    iRsn = 1'b1;
    repeat (2) step(1'b0, 8'd0);
  endtask

  task automatic test_ones();
    fill(0);
    for (int i = 0; i < 9; i++) k[i] = 8'sd1;
    set_k();
    iBias = 0;
    test_frame("ones", 1, 0);
  endtask

  task automatic test_ramp(input int gap);
    fill(1);
    for (int i = 0; i < 9; i++) k[i] = i == 4 ? 8'sd1 : 8'sd0;
    set_k();
    iBias = 0;
    holdErr = 0;
    test_frame(gap ? "ramp_gaps" : "ramp", 1, gap);
    tests++;
    if (holdErr !== 0) begin
      fails++;
      $display("FAIL hold_data: %0d idle cycles changed oOutData, expected 0", holdErr);
    end
  endtask

  task automatic test_extremes();
    fill(2);
    for (int i = 0; i < 9; i++) k[i] = -8'sd128;
    set_k();
    iBias = 0;
    test_frame("extreme_neg_neg", 1, 0);
    for (int i = 0; i < 9; i++) k[i] = 8'sd127;
    set_k();
    iBias = -5;
    test_frame("extreme_neg_pos", 1, 0);
  endtask

  task automatic test_random();
    fill(3);
    for (int i = 0; i < 9; i++) k[i] = 8'($urandom);
    set_k();
    iBias = 32'($urandom_range(0, 200000)) - 100000;
    test_frame("random_gaps", 2, 2);
  endtask

  task automatic test_midframe_reset();
    fill(0);
    for (int i = 0; i < 9; i++) k[i] = 8'sd1;
    set_k();
    iBias = 0;
    for (int r = 0; r <= 10; r++)
      for (int c = 0; c < W; c++) step(1'b1, 8'sd1);
    iRsn = 1'b0;
    #1;
    tests++;
    if (oOutValid !== 1'b0 || oOutData !== 32'sd0) begin
      fails++;
      $display("FAIL midreset_immediate: valid=%b data=%0d, expected 0/0", oOutValid, oOutData);
    end
    obsVal.delete();
    obsCyc.delete();
    repeat (3) step(1'b1, 8'sd1);
    iRsn = 1'b1;
    tests++;
    if (obsVal.size() !== 0) begin
      fails++;
      $display("FAIL midreset_pulses: got %0d pulses during reset, expected 0", obsVal.size());
    end
    test_frame("post_reset", 1, 0);
  endtask

  task automatic test_back_to_back();
    fill(0);
    for (int i = 0; i < 9; i++) k[i] = 8'sd1;
    set_k();
    iBias = 0;
    test_frame("back_to_back", 2, 0);
  endtask

  initial begin
    test_reset();
    test_ones();
    test_ramp(0);
    test_ramp(1);
    test_extremes();
    test_random();
    test_midframe_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
